// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data: each access is grant -> issue -> wait -> respond.
// A request seen in IDLE at t is acked at t+3 at the earliest. Requesters stall until their ack arrives; there is no queueing.
module mem_arbiter #(
    parameter int AWIDTH        = 32,
    parameter int DWIDTH        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic              ma_clk,
    input  logic              ma_rst,
    input  logic              ma_i_if_req,
    input  logic [AWIDTH-1:0] ma_i_if_addr,
    input  logic              ma_i_dm_req,
    input  logic              ma_i_dm_we,
    input  logic [AWIDTH-1:0] ma_i_dm_addr,
    input  logic [DWIDTH-1:0] ma_i_dm_wdata,
    input  logic              ma_i_flush,
    output logic              ma_o_if_ack,
    output logic [DWIDTH-1:0] ma_o_if_rdata,
    output logic              ma_o_dm_ack,
    output logic [DWIDTH-1:0] ma_o_dm_rdata,
    output logic              ma_o_stall_if,
    output logic              ma_o_stall_dm,
    output logic              ma_o_mem_ce,
    output logic              ma_o_mem_we,
    output logic [AWIDTH-1:0] ma_o_mem_addr,
    output logic [DWIDTH-1:0] ma_o_mem_wdata,
    input  logic [DWIDTH-1:0] ma_i_mem_rdata,
    input  logic              ma_i_mem_ack,
    output logic              ma_o_err
);
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    logic              r_own_if;
    logic              r_store;
    logic              r_flush_pend;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic              r_ce;
    logic              r_we;
    logic              r_err;
    logic [SW-1:0]     r_streak;
    logic [TW-1:0]     r_tmo;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata;

    logic w_grant_if;
    logic w_flush_if;
    logic w_done;

    // Data wins ties until it has starved a waiting fetch MAX_DM_STREAK times in a row.
    assign w_grant_if = ma_i_if_req & (~ma_i_dm_req | (r_streak == SW'(MAX_DM_STREAK)));
    assign w_flush_if = ma_i_flush & r_own_if;
    assign w_done     = ma_i_mem_ack | (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge ma_clk) begin
        if (ma_rst) begin
            r_state      <= S_IDLE;
            r_own_if     <= 1'b0;
            r_store      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_ce         <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_streak     <= '0;
            r_tmo        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_ce     <= 1'b0;
            r_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ma_i_if_req | ma_i_dm_req) begin
                        r_own_if <= w_grant_if;
                        r_ce     <= 1'b1;
                        r_state  <= S_ISSUE;
                        if (w_grant_if) begin
                            r_addr   <= ma_i_if_addr;
                            r_wdata  <= '0;
                            r_store  <= 1'b0;
                            r_streak <= '0;
                        end else begin
                            r_addr  <= ma_i_dm_addr;
                            r_wdata <= ma_i_dm_wdata;
                            r_store <= ma_i_dm_we;
                            r_we    <= ma_i_dm_we;
                            if (!ma_i_if_req)
                                r_streak <= '0;
                            else if (r_streak != SW'(MAX_DM_STREAK))
                                r_streak <= r_streak + SW'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    r_tmo <= '0;
                    if (w_flush_if) r_flush_pend <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_flush_if) r_flush_pend <= 1'b1;
                    if (w_done) begin
                        r_state  <= S_RESP;
                        r_rdata  <= (ma_i_mem_ack & ~r_store) ? ma_i_mem_rdata : '0;
                        r_if_ack <= r_own_if & ~r_flush_pend & ~ma_i_flush;
                        r_dm_ack <= ~r_own_if;
                        if (!ma_i_mem_ack) r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving in the response cycle itself must still kill the fetch ack.
    assign ma_o_if_ack    = r_if_ack & ~ma_i_flush;
    assign ma_o_dm_ack    = r_dm_ack;
    assign ma_o_if_rdata  = r_rdata;
    assign ma_o_dm_rdata  = r_rdata;
    assign ma_o_stall_if  = ma_i_if_req & ~ma_o_if_ack;
    assign ma_o_stall_dm  = ma_i_dm_req & ~ma_o_dm_ack;
    assign ma_o_mem_ce    = r_ce;
    assign ma_o_mem_we    = r_we;
    assign ma_o_mem_addr  = r_addr;
    assign ma_o_mem_wdata = r_wdata;
    assign ma_o_err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model schedules grants, memory latency and
// flushes; expected commands and responses go to queues that a negedge monitor pops and compares.
module tb_mem_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic        clk;
    logic        ma_rst;
    logic        ma_i_if_req;
    logic [31:0] ma_i_if_addr;
    logic        ma_i_dm_req;
    logic        ma_i_dm_we;
    logic [31:0] ma_i_dm_addr;
    logic [31:0] ma_i_dm_wdata;
    logic        ma_i_flush;
    logic        ma_o_if_ack;
    logic [31:0] ma_o_if_rdata;
    logic        ma_o_dm_ack;
    logic [31:0] ma_o_dm_rdata;
    logic        ma_o_stall_if;
    logic        ma_o_stall_dm;
    logic        ma_o_mem_ce;
    logic        ma_o_mem_we;
    logic [31:0] ma_o_mem_addr;
    logic [31:0] ma_o_mem_wdata;
    logic [31:0] ma_i_mem_rdata;
    logic        ma_i_mem_ack;
    logic        ma_o_err;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .ma_clk(clk), .ma_rst(ma_rst),
        .ma_i_if_req(ma_i_if_req), .ma_i_if_addr(ma_i_if_addr),
        .ma_i_dm_req(ma_i_dm_req), .ma_i_dm_we(ma_i_dm_we),
        .ma_i_dm_addr(ma_i_dm_addr), .ma_i_dm_wdata(ma_i_dm_wdata),
        .ma_i_flush(ma_i_flush),
        .ma_o_if_ack(ma_o_if_ack), .ma_o_if_rdata(ma_o_if_rdata),
        .ma_o_dm_ack(ma_o_dm_ack), .ma_o_dm_rdata(ma_o_dm_rdata),
        .ma_o_stall_if(ma_o_stall_if), .ma_o_stall_dm(ma_o_stall_dm),
        .ma_o_mem_ce(ma_o_mem_ce), .ma_o_mem_we(ma_o_mem_we),
        .ma_o_mem_addr(ma_o_mem_addr), .ma_o_mem_wdata(ma_o_mem_wdata),
        .ma_i_mem_rdata(ma_i_mem_rdata), .ma_i_mem_ack(ma_i_mem_ack),
        .ma_o_err(ma_o_err)
    );

    typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } ce_t;
    typedef struct { int cyc; bit is_if; logic [31:0] rdata; } rsp_t;
    ce_t  ceq[$];
    rsp_t rq[$];

    int n_chk = 0, n_fail = 0, cyc = 0, n_if_seen = 0, n_dm_seen = 0;
    bit chk_en = 0, exp_err = 0;

    // stimulus / model state
    bit          gen_en = 0, rst_req = 0, rst_prev = 0, force_tmo = 0;
    int          load = 30, rst_at = -1, force_ack_at = -1, streak = 0;
    bit          if_pend = 0, dm_pend = 0, dm_we = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
    bit          busy = 0, t_if = 0, t_we = 0, t_tmo = 0, t_supp = 0;
    int          t_g = 0, t_ack = 0, t_r = 0;
    logic [31:0] t_addr = 0, t_wd = 0, t_mdat = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model reasons in whole transactions (grant cycle, ack cycle, response cycle).
    task automatic step();
        int lat;
        bit rst_now, flush, ack;
        logic [31:0] mrd;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_prev) begin
            busy = 0; if_pend = 0; dm_pend = 0; streak = 0; exp_err = 0;
        end
        if (busy && cyc == t_r + 1) begin
            busy = 0;
            if (!t_supp) begin
                if (t_if) if_pend = 0; else dm_pend = 0;
            end
        end
        if (gen_en && !if_pend && $urandom_range(0, 99) < load) begin
            if_pend = 1;
            if_addr = $urandom_range(0, 1023) << 2;
        end
        if (gen_en && !dm_pend && $urandom_range(0, 99) < load) begin
            dm_pend  = 1;
            dm_we    = $urandom_range(0, 1) == 1;
            dm_addr  = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
            dm_wdata = $urandom;
        end
        flush   = ($urandom_range(0, 9) == 0);
        rst_now = rst_req || (cyc == rst_at);
        if (busy && t_if && flush && cyc >= t_g + 1) t_supp = 1;

        mrd = $urandom;
        if (busy && cyc == t_ack && !t_tmo) begin
            ack = 1; mrd = t_mdat;
        end else if (busy && cyc >= t_g + 2 && cyc < t_r) begin
            ack = 0;
        end else begin
            ack = ($urandom_range(0, 2) == 0) || (cyc == force_ack_at);
        end

        if (busy && cyc == t_g + 1) ceq.push_back('{cyc, t_addr, t_we, t_wd});
        if (busy && cyc == t_r) begin
            if (t_tmo) exp_err = 1;
            if (!t_supp) rq.push_back('{cyc, t_if, (t_we || t_tmo) ? 32'h0 : t_mdat});
        end

        if (!busy && !rst_now && (if_pend || dm_pend)) begin
            t_if = if_pend && (!dm_pend || streak == MAXS);
            if (t_if) streak = 0;
            else if (if_pend) streak = (streak < MAXS) ? streak + 1 : MAXS;
            else streak = 0;
            busy   = 1;
            t_supp = 0;
            t_g    = cyc;
            t_addr = t_if ? if_addr : dm_addr;
            t_we   = t_if ? 1'b0 : dm_we;
            t_wd   = dm_wdata;
            lat    = $urandom_range(0, 19);
            lat    = (lat < 12) ? lat % 4 : (lat < 17 ? int'($urandom_range(4, 15)) : TMO);
            if (force_tmo) lat = TMO;
            t_tmo  = lat >= TMO;
            t_ack  = cyc + 2 + lat;
            t_r    = cyc + 3 + (t_tmo ? TMO - 1 : lat);
            t_mdat = $urandom;
        end

        ma_rst         = rst_now;
        ma_i_if_req    = if_pend;
        ma_i_if_addr   = if_addr;
        ma_i_dm_req    = dm_pend;
        ma_i_dm_we     = dm_we;
        ma_i_dm_addr   = dm_addr;
        ma_i_dm_wdata  = dm_wdata;
        ma_i_flush     = flush;
        ma_i_mem_ack   = ack;
        ma_i_mem_rdata = mrd;
        rst_prev       = rst_now;
    endtask

    always @(negedge clk) begin : mon
        bit e_ce, e_ifa, e_dma;
        if (chk_en) begin
            e_ce = ceq.size() > 0 && ceq[0].cyc == cyc;
            chk("mem_ce", {31'b0, ma_o_mem_ce}, {31'b0, e_ce});
            chk("mem_we", {31'b0, ma_o_mem_we}, {31'b0, e_ce && ceq[0].we});
            if (e_ce) begin
                chk("mem_addr", ma_o_mem_addr, ceq[0].addr);
                if (ceq[0].we) chk("mem_wdata", ma_o_mem_wdata, ceq[0].wdata);
                void'(ceq.pop_front());
            end
            e_ifa = rq.size() > 0 && rq[0].cyc == cyc && rq[0].is_if;
            e_dma = rq.size() > 0 && rq[0].cyc == cyc && !rq[0].is_if;
            chk("if_ack", {31'b0, ma_o_if_ack}, {31'b0, e_ifa});
            chk("dm_ack", {31'b0, ma_o_dm_ack}, {31'b0, e_dma});
            if (e_ifa) chk("if_rdata", ma_o_if_rdata, rq[0].rdata);
            if (e_dma) chk("dm_rdata", ma_o_dm_rdata, rq[0].rdata);
            if (e_ifa || e_dma) void'(rq.pop_front());
            chk("stall_if", {31'b0, ma_o_stall_if}, {31'b0, ma_i_if_req & ~e_ifa});
            chk("stall_dm", {31'b0, ma_o_stall_dm}, {31'b0, ma_i_dm_req & ~e_dma});
            chk("err", {31'b0, ma_o_err}, {31'b0, exp_err});
            if (ma_o_if_ack) n_if_seen++;
            if (ma_o_dm_ack) n_dm_seen++;
        end
    end

    initial begin
        ma_rst = 1; ma_i_if_req = 0; ma_i_if_addr = 0; ma_i_dm_req = 0; ma_i_dm_we = 0;
        ma_i_dm_addr = 0; ma_i_dm_wdata = 0; ma_i_flush = 0; ma_i_mem_rdata = 0; ma_i_mem_ack = 0;

        rst_req = 1;
        step();
        step();
        chk_en = 1;
        step();
        rst_req = 0;
        chk("rst_mem_addr", ma_o_mem_addr, 32'h0);
        chk("rst_mem_wdata", ma_o_mem_wdata, 32'h0);
        chk("rst_if_rdata", ma_o_if_rdata, 32'h0);
        chk("rst_dm_rdata", ma_o_dm_rdata, 32'h0);

        gen_en = 1;
        load = 30;
        repeat (1500) step();
        load = 100;
        repeat (1500) step();

        gen_en = 0;
        for (int i = 0; i < 400 && (busy || if_pend || dm_pend); i++) step();
        chk("drained", {29'b0, busy, if_pend, dm_pend}, 32'h0);

        // load stuck in WAIT, reset mid-transaction, then a late memory ack
        dm_pend = 1; dm_we = 0; dm_addr = 32'h8000_0100; force_tmo = 1;
        step();
        force_tmo = 0;
        rst_at = t_g + 3;
        force_ack_at = t_g + 4;
        repeat (8) step();
        chk("post_rst_mem_addr", ma_o_mem_addr, 32'h0);
        chk("post_rst_mem_wdata", ma_o_mem_wdata, 32'h0);
        chk("post_rst_rdata", ma_o_dm_rdata, 32'h0);
        chk("post_rst_err", {31'b0, ma_o_err}, 32'h0);

        chk("ce_queue_empty", ceq.size(), 32'h0);
        chk("rsp_queue_empty", rq.size(), 32'h0);
        chk("if_acks_seen", {31'b0, n_if_seen > 10}, 32'h1);
        chk("dm_acks_seen", {31'b0, n_dm_seen > 10}, 32'h1);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
